// File: rtl/ntp_pkg.sv
// Shared constants for the PPS/time link: status bit layout, frame length
// and the 8N1 framing of one 32-bit seconds word.
package ntp_pkg;

    localparam logic [31:0] NTP_SECONDS_AT_POSIX_EPOCH = 32'd2208988800;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_PENDING = 1;
    localparam int unsigned ST_OVERRUN = 2;
    localparam int unsigned ST_TOGGLE  = 31;

    localparam int unsigned FRAME_BITS = 40;

    // Bit 0 goes out first: MSB byte first, each byte start/LSB..MSB/stop.
    function automatic logic [FRAME_BITS-1:0] buildFrame(input logic [31:0] word);
        return {1'b1, word[7:0],   1'b0,
                1'b1, word[15:8],  1'b0,
                1'b1, word[23:16], 1'b0,
                1'b1, word[31:24], 1'b0};
    endfunction

endpackage

// File: rtl/ntp_word_serializer.sv
// Shifts one 32-bit word out as four back-to-back 8N1 bytes, DIV clocks per bit.
module ntp_word_serializer
    import ntp_pkg::*;
#(
    parameter int unsigned DIV = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    input  logic        start,
    input  logic [31:0] word,
    output logic        txd,
    output logic        busy
);

    localparam int unsigned DW = $clog2(DIV + 1);

    logic [DW-1:0]           divCnt;
    logic [5:0]              bitCnt;
    logic [FRAME_BITS-2:0]   shiftReg;
    logic [FRAME_BITS-1:0]   frame;

    always_comb frame = buildFrame(word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd      <= 1'b1;
            busy     <= 1'b0;
            divCnt   <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
        end else if (abort) begin
            txd    <= 1'b1;
            busy   <= 1'b0;
            divCnt <= '0;
            bitCnt <= '0;
        end else if (start) begin
            txd      <= frame[0];
            shiftReg <= frame[FRAME_BITS-1:1];
            busy     <= 1'b1;
            divCnt   <= '0;
            bitCnt   <= '0;
        end else if (busy) begin
            if (divCnt == DW'(DIV - 1)) begin
                divCnt <= '0;
                if (bitCnt == 6'(FRAME_BITS - 1)) begin
                    busy <= 1'b0;
                    txd  <= 1'b1;
                end else begin
                    bitCnt   <= bitCnt + 6'd1;
                    txd      <= shiftReg[0];
                    shiftReg <= {1'b0, shiftReg[FRAME_BITS-2:1]};
                end
            end else begin
                divCnt <= divCnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/ntp_pps_transmitter.sv
// Transmit end of the PPS/time link: free-running second counter, PPS pulse,
// software-loaded next second and a serial time code after every PPS edge.
module ntp_pps_transmitter
    import ntp_pkg::*;
#(
    parameter int unsigned CLK_RATE  = 100000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned PPS_WIDTH = CLK_RATE / 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        writeStrobe,
    input  logic [31:0] writeData,
    output logic        ppsOut,
    output logic        txd,
    output logic [31:0] seconds,
    output logic        busy,
    output logic [31:0] status
);

    localparam int unsigned DIV = CLK_RATE / BAUD;
    localparam int unsigned TW  = $clog2(CLK_RATE);
    localparam int unsigned PW  = $clog2(PPS_WIDTH + 1);

    generate
        if (DIV < 1 || FRAME_BITS * DIV >= CLK_RATE) begin : gFrameCheck
            $fatal(1, "ntp_pps_transmitter: serial frame does not fit in one second");
        end
        if (PPS_WIDTH < 1 || PPS_WIDTH >= CLK_RATE) begin : gWidthCheck
            $fatal(1, "ntp_pps_transmitter: PPS_WIDTH out of range");
        end
    endgenerate

    logic [TW-1:0] tickCounter;
    logic [PW-1:0] ppsLeft;
    logic          ppsToggle;
    logic [31:0]   pending;
    logic          pendingValid;
    logic          overrun;
    logic          startFrame;
    logic          wrap;

    always_comb wrap = enable && (tickCounter == TW'(CLK_RATE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tickCounter  <= '0;
            ppsOut       <= 1'b0;
            ppsLeft      <= '0;
            ppsToggle    <= 1'b0;
            seconds      <= '0;
            pending      <= '0;
            pendingValid <= 1'b0;
            overrun      <= 1'b0;
            startFrame   <= 1'b0;
        end else begin
            if (writeStrobe && pendingValid)
                overrun <= 1'b1;

            // A write landing on the wrap cycle goes straight into this PPS.
            if (wrap) begin
                pendingValid <= 1'b0;
                seconds      <= writeStrobe  ? writeData :
                                pendingValid ? pending   : seconds + 32'd1;
            end else if (writeStrobe) begin
                pending      <= writeData;
                pendingValid <= 1'b1;
            end

            if (!enable) begin
                tickCounter <= '0;
                ppsOut      <= 1'b0;
                ppsLeft     <= '0;
                startFrame  <= 1'b0;
            end else begin
                startFrame <= wrap;
                if (wrap) begin
                    tickCounter <= '0;
                    ppsOut      <= 1'b1;
                    ppsLeft     <= PW'(PPS_WIDTH - 1);
                    ppsToggle   <= ~ppsToggle;
                end else begin
                    tickCounter <= tickCounter + TW'(1);
                    if (ppsOut) begin
                        if (ppsLeft == '0)
                            ppsOut <= 1'b0;
                        else
                            ppsLeft <= ppsLeft - PW'(1);
                    end
                end
            end
        end
    end

    ntp_word_serializer #(
        .DIV(DIV)
    ) uSerializer (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (!enable),
        .start (startFrame),
        .word  (seconds),
        .txd   (txd),
        .busy  (busy)
    );

    always_comb begin
        status             = '0;
        status[ST_BUSY]    = busy;
        status[ST_PENDING] = pendingValid;
        status[ST_OVERRUN] = overrun;
        status[ST_TOGGLE]  = ppsToggle;
    end

endmodule

// File: tb/tb_ntp_pps_transmitter.sv
// Bench for ntp_pps_transmitter: table of one-second write scenarios, directed
// reset/enable sequences and random traffic against a cycle-count reference model.
module tb_ntp_pps_transmitter;

    localparam int CR    = 1000;
    localparam int BD    = 100;
    localparam int PWID  = 100;
    localparam int DIVB  = CR / BD;
    localparam int FRAME = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        writeStrobe = 1'b0;
    logic [31:0] writeData = '0;
    logic        ppsOut, txd, busy;
    logic [31:0] seconds, status;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: seconds bookkeeping plus elapsed-time counters.
    int          mEnCount;
    int          mSinceP;
    logic [31:0] mSec, mPend, mWord;
    bit          mPendV, mOver, mTog;

    typedef struct {
        int          w1At;
        logic [31:0] w1;
        int          w2At;
        logic [31:0] w2;
        logic [31:0] expSec;
        bit          expPendBefore;
        bit          expOver;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    ntp_pps_transmitter #(
        .CLK_RATE  (CR),
        .BAUD      (BD),
        .PPS_WIDTH (PWID)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .writeStrobe (writeStrobe),
        .writeData   (writeData),
        .ppsOut      (ppsOut),
        .txd         (txd),
        .seconds     (seconds),
        .busy        (busy),
        .status      (status)
    );

    function automatic logic frameBit(input logic [31:0] w, input int k);
        int b, p;
        logic [7:0] by;
        b  = k / 10;
        p  = k % 10;
        by = 8'(w >> (8 * (3 - b)));
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[p-1];
    endfunction

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        mEnCount = 0;
        mSinceP  = -1;
        mSec     = '0;
        mPend    = '0;
        mWord    = '0;
        mPendV   = 1'b0;
        mOver    = 1'b0;
        mTog     = 1'b0;
    endtask

    task automatic modelEdge();
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (enable) begin
            mEnCount++;
        end else begin
            mEnCount = 0;
            mSinceP  = -1;
        end
        if (enable && (mEnCount % CR == 0)) begin
            if (writeStrobe && mPendV) mOver = 1'b1;
            mSec    = writeStrobe ? writeData : (mPendV ? mPend : mSec + 32'd1);
            mPendV  = 1'b0;
            mTog    = ~mTog;
            mSinceP = 0;
            mWord   = mSec;
        end else begin
            if (mSinceP >= 0) mSinceP++;
            if (writeStrobe) begin
                if (mPendV) mOver = 1'b1;
                mPend  = writeData;
                mPendV = 1'b1;
            end
        end
    endtask

    task automatic compareModel();
        bit          ePps, eBusy, eTxd;
        logic [31:0] eStat;
        ePps  = (mSinceP >= 0) && (mSinceP < PWID);
        eBusy = (mSinceP >= 1) && (mSinceP <= FRAME * DIVB);
        eTxd  = eBusy ? frameBit(mWord, (mSinceP - 1) / DIVB) : 1'b1;
        eStat = {mTog, 28'b0, mOver, mPendV, eBusy};
        check("cycleModel", {ppsOut, txd, busy, seconds, status},
              {ePps, eTxd, eBusy, mSec, eStat});
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        modelEdge();
        #1;
        compareModel();
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout required finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] prevSec;

        vecs[0] = '{-1,  32'h0,        -1,  32'h0, 32'd3,        1'b0, 1'b0};
        vecs[1] = '{500, 32'hE1234567, -1,  32'h0, 32'hE1234567, 1'b1, 1'b0};
        vecs[2] = '{-1,  32'h0,        -1,  32'h0, 32'hE1234568, 1'b0, 1'b0};
        vecs[3] = '{999, 32'h10,       -1,  32'h0, 32'h10,       1'b0, 1'b0};
        vecs[4] = '{-1,  32'h0,        -1,  32'h0, 32'h11,       1'b0, 1'b0};
        vecs[5] = '{100, 32'hFFFFFFFF, -1,  32'h0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{-1,  32'h0,        -1,  32'h0, 32'h0,        1'b0, 1'b0};
        vecs[7] = '{300, 32'hA,        600, 32'hB, 32'hB,        1'b1, 1'b1};
        vecs[8] = '{-1,  32'h0,        -1,  32'h0, 32'hC,        1'b0, 1'b1};

        modelReset();
        repeat (3) tick();
        check("resetOutputs", {ppsOut, txd, busy, seconds, status},
              {1'b0, 1'b1, 1'b0, 32'h0, 32'h0});

        // Free run from enable, no writes.
        rst_n  = 1'b1;
        enable = 1'b1;
        for (int t = 1; t <= 2 * CR; t++) begin
            tick();
            if (t == CR - 1) check("ppsBeforeFirst", ppsOut, 0);
            if (t == CR) begin
                check("pps1", ppsOut, 1);
                check("sec1", seconds, 1);
                check("toggle1", status[31], 1);
            end
            if (t == CR + PWID - 1) check("ppsLastHigh", ppsOut, 1);
            if (t == CR + PWID) check("ppsFall", ppsOut, 0);
            if (t == 2 * CR) begin
                check("pps2", ppsOut, 1);
                check("sec2", seconds, 2);
                check("toggle2", status[31], 0);
            end
        end

        // One second per vector; p counts cycles since the previous PPS.
        prevSec = 32'd2;
        foreach (vecs[i]) begin
            for (int p = 1; p <= CR; p++) begin
                writeStrobe = (p - 1 == vecs[i].w1At) || (p - 1 == vecs[i].w2At);
                writeData   = (p - 1 == vecs[i].w2At) ? vecs[i].w2 : vecs[i].w1;
                tick();
                if (p == 1) check("frameStart", {busy, txd}, 2'b10);
                if (p <= FRAME * DIVB && (p - 1) % DIVB == DIVB / 2)
                    check("txdBit", txd, frameBit(prevSec, (p - 1) / DIVB));
                if (p == FRAME * DIVB) check("busyLast", busy, 1);
                if (p == FRAME * DIVB + 1) check("busyEnd", {busy, txd}, 2'b01);
                if (p == CR - 1) check("pendingBeforePps", status[1], vecs[i].expPendBefore);
                if (p == CR) begin
                    writeStrobe = 1'b0;
                    check("vecSeconds", seconds, vecs[i].expSec);
                    check("vecPendingAfter", status[1], 0);
                    check("vecOverrun", status[2], vecs[i].expOver);
                end
            end
            prevSec = vecs[i].expSec;
        end

        // Asynchronous reset during byte 2 of a frame.
        repeat (250) tick();
        #3 rst_n = 1'b0;
        #1;
        check("asyncReset", {ppsOut, txd, busy, seconds, status},
              {1'b0, 1'b1, 1'b0, 32'h0, 32'h0});
        modelReset();
        repeat (3) tick();
        rst_n = 1'b1;
        for (int t = 1; t <= CR; t++) begin
            tick();
            if (t == CR - 1) check("postResetNoPps", ppsOut, 0);
            if (t == CR) check("postResetPps", {ppsOut, seconds}, {1'b1, 32'd1});
        end

        // Enable drop while PPS is high and a frame is running.
        repeat (50) tick();
        check("midPulseMidFrame", {ppsOut, busy}, 2'b11);
        enable = 1'b0;
        tick();
        check("disableOutputs", {ppsOut, txd, busy, seconds}, {1'b0, 1'b1, 1'b0, 32'd1});
        repeat (20) tick();
        check("disabledHold", seconds, 1);
        enable = 1'b1;
        for (int t = 1; t <= CR; t++) begin
            tick();
            if (t == CR - 1) check("reenableNoPps", ppsOut, 0);
            if (t == CR) check("reenablePps", {ppsOut, seconds}, {1'b1, 32'd2});
        end

        // Random writes and enable drops, including writes on the wrap cycle.
        for (int r = 0; r < 8000; r++) begin
            if (!enable) begin
                if ($urandom_range(0, 9) == 0) enable = 1'b1;
            end else if ($urandom_range(0, 1999) == 0) begin
                enable = 1'b0;
            end
            writeStrobe = ($urandom_range(0, 249) == 0) ||
                          (enable && (mEnCount % CR == CR - 1) && ($urandom_range(0, 3) == 0));
            writeData   = $urandom;
            tick();
        end
        writeStrobe = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
